// File: rtl/hs_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : hs_rx_deserializer
// Brief    : DDR high-speed receive deserializer. Captures Dp on both clock
//            edges, hunts for the HS leader sync byte at either bit phase,
//            then assembles LSB-first payload bytes until Enable drops.
// Revision : 1.0 - initial release
// ============================================================================
module hs_rx_deserializer #(
  parameter logic [7:0] SYNC_BYTE = 8'hB8,
  parameter int         HUNT_MAX  = 64
) (
  input  logic       RX_DDR_clk,
  input  logic       RX_rst_n,
  input  logic       Enable,
  input  logic       Dp,
  input  logic       Dn,
  output logic [7:0] RX_byte,
  output logic       RX_valid,
  output logic       RX_active,
  output logic       RX_sync_err,
  output logic       RX_line_err
);

  localparam int               c_CW        = $clog2(HUNT_MAX + 1);
  localparam logic [c_CW-1:0]  c_HUNT_LAST = c_CW'(HUNT_MAX - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_HUNT = 2'd1;
  localparam logic [1:0] c_DATA = 2'd2;
  localparam logic [1:0] c_ERR  = 2'd3;

  logic [1:0]      r_state;
  logic            r_neg_dp;     // bit n: Dp captured on the falling edge
  logic            r_neg_eq;     // Dp==Dn seen on the falling edge with Enable high
  logic [9:0]      r_sr;
  logic [c_CW-1:0] r_hunt_cnt;
  logic [1:0]      r_pair_cnt;
  logic            r_phase;
  logic [7:0]      r_byte;
  logic            r_valid;
  logic            r_active;
  logic            r_sync_err;
  logic            r_line_err;

  logic [9:0]      w_sr_next;
  logic            w_match0;
  logic            w_match1;
  logic            w_line_bad;
  logic [1:0]      w_unused_sr_tail;

  // Post-update view of the shift register: newest bit (p) lands in the MSB.
  assign w_sr_next  = {Dp, r_neg_dp, r_sr[9:2]};
  assign w_match0   = (w_sr_next[9:2] == SYNC_BYTE);
  assign w_match1   = (w_sr_next[8:1] == SYNC_BYTE);
  assign w_line_bad = r_neg_eq | (Enable & (Dp == Dn));

  // The two oldest bits only extend the sliding window; nothing reads them.
  assign w_unused_sr_tail = r_sr[1:0];

  // Falling-edge capture of the earlier bit of each pair and its line check.
  always_ff @(negedge RX_DDR_clk or negedge RX_rst_n) begin
    if (!RX_rst_n) begin
      r_neg_dp <= 1'b0;
      r_neg_eq <= 1'b0;
    end else begin
      if (Enable) r_neg_dp <= Dp;
      r_neg_eq <= Enable & (Dp == Dn);
    end
  end

  // Rising-edge FSM: hunt for sync, then emit a byte every fourth bit pair.
  always_ff @(posedge RX_DDR_clk or negedge RX_rst_n) begin
    if (!RX_rst_n) begin
      r_state    <= c_IDLE;
      r_sr       <= '0;
      r_hunt_cnt <= '0;
      r_pair_cnt <= '0;
      r_phase    <= 1'b0;
      r_byte     <= 8'h00;
      r_valid    <= 1'b0;
      r_active   <= 1'b0;
      r_sync_err <= 1'b0;
      r_line_err <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_sync_err <= 1'b0;
      if (w_line_bad) r_line_err <= 1'b1;

      if (r_state == c_IDLE) begin
        if (Enable) begin
          // Fresh hunt: old history and the sticky line flag are forgotten.
          r_state    <= c_HUNT;
          r_sr       <= '0;
          r_hunt_cnt <= '0;
          r_pair_cnt <= '0;
          r_phase    <= 1'b0;
          r_line_err <= 1'b0;
        end
      end else if (!Enable) begin
        // Leaving HS mode aborts any partial byte.
        r_state  <= c_IDLE;
        r_active <= 1'b0;
      end else begin
        r_sr <= w_sr_next;
        case (r_state)
          c_HUNT: begin
            if (w_match0 || w_match1) begin
              r_state    <= c_DATA;
              r_phase    <= ~w_match0;   // even alignment wins a tie
              r_pair_cnt <= 2'd0;
              r_active   <= 1'b1;
            end else if (r_hunt_cnt == c_HUNT_LAST) begin
              r_state    <= c_ERR;
              r_sync_err <= 1'b1;
            end else begin
              r_hunt_cnt <= r_hunt_cnt + c_CW'(1);
            end
          end
          c_DATA: begin
            r_pair_cnt <= r_pair_cnt + 2'd1;
            if (r_pair_cnt == 2'd3) begin
              r_byte  <= r_phase ? w_sr_next[8:1] : w_sr_next[9:2];
              r_valid <= 1'b1;
            end
          end
          default: begin
            // ERR: wait for Enable to drop.
          end
        endcase
      end
    end
  end

  assign RX_byte     = r_byte;
  assign RX_valid    = r_valid;
  assign RX_active   = r_active;
  assign RX_sync_err = r_sync_err;
  assign RX_line_err = r_line_err;

endmodule
`default_nettype wire

// File: tb/tb_hs_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_rx_deserializer
// Brief    : Self-checking bench for hs_rx_deserializer: table-driven bursts,
//            hand-written corner sequences and randomized bursts, all checked
//            against a bit-stream level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs_rx_deserializer;

  localparam logic [7:0] c_SYNC     = 8'hB8;
  localparam int         c_HUNT_MAX = 64;
  localparam int         M_OFF = 0, M_SEARCH = 1, M_LOCK = 2, M_FAIL = 3;

  logic       r_clk, r_rst_n, r_en, r_dp, r_dn;
  logic [7:0] w_byte;
  logic       w_valid, w_active, w_sync_err, w_line_err;

  hs_rx_deserializer #(.SYNC_BYTE(c_SYNC), .HUNT_MAX(c_HUNT_MAX)) dut (
    .RX_DDR_clk (r_clk),
    .RX_rst_n   (r_rst_n),
    .Enable     (r_en),
    .Dp         (r_dp),
    .Dn         (r_dn),
    .RX_byte    (w_byte),
    .RX_valid   (w_valid),
    .RX_active  (w_active),
    .RX_sync_err(w_sync_err),
    .RX_line_err(w_line_err)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_sync = 0;

  // Reference model: the received bit stream since the last hunt start.
  int         m_mode;
  bit         m_bits[$];
  int         m_hunt, m_lock, m_emitted;
  logic [7:0] m_byte;
  logic       m_valid, m_active, m_sync_err, m_line;

  logic [7:0] log_byte[$];
  int         log_cyc[$];
  bit         tx[$];

  typedef struct {
    int         lead;
    int         nbytes;
    logic [7:0] b [3];
    int         nv;
    logic [7:0] eb [2];
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_at(input int start);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = m_bits[start + i];
    return r;
  endfunction

  function automatic void model_reset();
    m_mode = M_OFF; m_bits.delete(); m_hunt = 0; m_lock = 0; m_emitted = 0;
    m_byte = 8'h00; m_valid = 0; m_active = 0; m_sync_err = 0; m_line = 0;
  endfunction

  function automatic void model_cycle(input bit e, input bit n, input bit p,
                                      input bit dnn, input bit dnp);
    int len;
    m_valid    = 0;
    m_sync_err = 0;
    if (e && (n == dnn || p == dnp)) m_line = 1;
    if (!e) begin
      m_mode = M_OFF;
    end else if (m_mode == M_OFF) begin
      // History before a hunt reads as zeros; this pair is not kept.
      m_mode = M_SEARCH;
      m_bits.delete();
      repeat (10) m_bits.push_back(1'b0);
      m_hunt = 0;
      m_line = 0;
    end else begin
      m_bits.push_back(n);
      m_bits.push_back(p);
      len = m_bits.size();
      if (m_mode == M_SEARCH) begin
        m_hunt++;
        if (byte_at(len - 8) == c_SYNC) begin
          m_lock = len; m_mode = M_LOCK; m_emitted = 0;
        end else if (byte_at(len - 9) == c_SYNC) begin
          m_lock = len - 1; m_mode = M_LOCK; m_emitted = 0;
        end else if (m_hunt == c_HUNT_MAX) begin
          m_mode = M_FAIL; m_sync_err = 1;
        end
      end else if (m_mode == M_LOCK) begin
        if (len - m_lock >= 8 * (m_emitted + 1)) begin
          m_byte  = byte_at(m_lock + 8 * m_emitted);
          m_emitted++;
          m_valid = 1;
        end
      end
    end
    m_active = (m_mode == M_LOCK);
  endfunction

  // One clock: n driven before the falling edge, p before the rising edge.
  task automatic step(input bit e, input bit n, input bit p, input bit dnn, input bit dnp);
    r_en = e; r_dp = n; r_dn = dnn;
    @(negedge r_clk); #1;
    r_dp = p; r_dn = dnp;
    @(posedge r_clk); #1;
    cyc++;
    model_cycle(e, n, p, dnn, dnp);
    chk("RX_valid",    int'(w_valid),    int'(m_valid));
    chk("RX_byte",     int'(w_byte),     int'(m_byte));
    chk("RX_active",   int'(w_active),   int'(m_active));
    chk("RX_sync_err", int'(w_sync_err), int'(m_sync_err));
    chk("RX_line_err", int'(w_line_err), int'(m_line));
    if (w_valid) begin log_byte.push_back(w_byte); log_cyc.push_back(cyc); end
    if (w_sync_err) n_sync++;
  endtask

  task automatic clean(input bit e, input bit n, input bit p);
    step(e, n, p, ~n, ~p);
  endtask

  task automatic push_zeros(input int k);
    for (int i = 0; i < k; i++) tx.push_back(1'b0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx.push_back(b[i]);
  endtask

  task automatic send_tx();
    bit n, p;
    if (tx.size() % 2 == 1) tx.push_back(1'b0);
    while (tx.size() > 0) begin
      n = tx.pop_front();
      p = tx.pop_front();
      clean(1'b1, n, p);
    end
  endtask

  task automatic clear_log();
    log_byte.delete(); log_cyc.delete();
  endtask

  task automatic do_reset();
    r_rst_n = 1'b0;
    #1;
    chk("rst_byte",     int'(w_byte),     0);
    chk("rst_valid",    int'(w_valid),    0);
    chk("rst_active",   int'(w_active),   0);
    chk("rst_sync_err", int'(w_sync_err), 0);
    chk("rst_line_err", int'(w_line_err), 0);
    model_reset();
    @(posedge r_clk); #1;
    r_rst_n = 1'b1;
  endtask

  function automatic void set_vec(input int k, input int lead, input int nb,
                                  input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                  input int nv, input logic [7:0] e0, input logic [7:0] e1);
    vecs[k].lead = lead; vecs[k].nbytes = nb;
    vecs[k].b[0] = b0; vecs[k].b[1] = b1; vecs[k].b[2] = b2;
    vecs[k].nv = nv; vecs[k].eb[0] = e0; vecs[k].eb[1] = e1;
  endfunction

  task automatic run_vec(input int k);
    int ac;
    clear_log();
    clean(1'b0, 1'b0, 1'b0);
    clean(1'b1, 1'b0, 1'b0);
    push_zeros(vecs[k].lead);
    for (int j = 0; j < vecs[k].nbytes; j++) push_byte(vecs[k].b[j]);
    send_tx();
    clean(1'b0, 1'b0, 1'b0);
    chk($sformatf("vec%0d_active_off", k), int'(w_active), 0);
    chk($sformatf("vec%0d_nvalid", k), log_byte.size(), vecs[k].nv);
    for (int i = 0; i < vecs[k].nv; i++) begin
      ac = (i < log_byte.size()) ? int'(log_byte[i]) : -1;
      chk($sformatf("vec%0d_byte%0d", k, i), ac, int'(vecs[k].eb[i]));
    end
    if (vecs[k].nv == 2) begin
      ac = (log_cyc.size() >= 2) ? (log_cyc[1] - log_cyc[0]) : -1;
      chk($sformatf("vec%0d_gap", k), ac, 4);
    end
  endtask

  initial begin
    int first_err;
    int len, kind;
    bit n, p, dnn, dnp;

    set_vec(0, 16, 3, 8'hB8, 8'h5A, 8'hC3, 2, 8'h5A, 8'hC3);  // even alignment
    set_vec(1, 15, 2, 8'hB8, 8'hA5, 8'h00, 1, 8'hA5, 8'h00);  // odd alignment
    set_vec(2, 16, 3, 8'hB8, 8'hB8, 8'h3C, 2, 8'hB8, 8'h3C);  // sync value in payload is data
    set_vec(3,  3, 2, 8'hB8, 8'hFF, 8'h00, 1, 8'hFF, 8'h00);  // odd, short lead
    set_vec(4,  0, 2, 8'hB8, 8'h81, 8'h00, 1, 8'h81, 8'h00);  // even, no lead

    r_rst_n = 1'b0; r_en = 1'b0; r_dp = 1'b0; r_dn = 1'b1;
    model_reset();
    repeat (2) @(posedge r_clk);
    #1;
    chk("reset_byte",     int'(w_byte),     0);
    chk("reset_valid",    int'(w_valid),    0);
    chk("reset_active",   int'(w_active),   0);
    chk("reset_sync_err", int'(w_sync_err), 0);
    chk("reset_line_err", int'(w_line_err), 0);
    r_rst_n = 1'b1;

    for (int k = 0; k < 5; k++) run_vec(k);

    // Hunt timeout on all-zero data, then recovery after an Enable toggle.
    clean(1'b0, 1'b0, 1'b0);
    clean(1'b1, 1'b0, 1'b0);
    clear_log(); n_sync = 0; first_err = -1;
    for (int i = 1; i <= 70; i++) begin
      clean(1'b1, 1'b0, 1'b0);
      if (w_sync_err && first_err < 0) first_err = i;
    end
    chk("timeout_pulses", n_sync, 1);
    chk("timeout_cycle",  first_err, c_HUNT_MAX);
    chk("timeout_valids", log_byte.size(), 0);
    run_vec(0);

    // Truncated byte: 6 payload bits then Enable low.
    clean(1'b0, 1'b0, 1'b0);
    clean(1'b1, 1'b0, 1'b0);
    push_zeros(16); push_byte(c_SYNC); send_tx();
    chk("trunc_locked", int'(w_active), 1);
    clear_log();
    for (int i = 0; i < 6; i++) tx.push_back(i[0]);
    send_tx();
    clean(1'b0, 1'b0, 1'b0);
    chk("trunc_active_drop", int'(w_active), 0);
    repeat (3) clean(1'b0, 1'b0, 1'b0);
    chk("trunc_valids", log_byte.size(), 0);

    // Line error in DATA: sticky through idle until the next hunt entry.
    clean(1'b1, 1'b0, 1'b0);
    push_zeros(16); push_byte(c_SYNC); send_tx();
    chk("line_before", int'(w_line_err), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("line_set", int'(w_line_err), 1);
    repeat (5) clean(1'b1, 1'b1, 1'b0);
    clean(1'b0, 1'b0, 1'b0);
    clean(1'b0, 1'b0, 1'b0);
    chk("line_sticky_idle", int'(w_line_err), 1);
    clean(1'b1, 1'b0, 1'b0);
    chk("line_clear_hunt", int'(w_line_err), 0);
    clean(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a byte, then a clean burst.
    clean(1'b1, 1'b0, 1'b0);
    push_zeros(16); push_byte(c_SYNC); send_tx();
    clean(1'b1, 1'b1, 1'b0);
    clean(1'b1, 1'b0, 1'b1);
    chk("rst_pre_active", int'(w_active), 1);
    clear_log();
    do_reset();
    clean(1'b0, 1'b0, 1'b0);
    chk("rst_no_valid", log_byte.size(), 0);
    run_vec(0);

    // Randomized bursts against the model.
    for (int b = 0; b < 40; b++) begin
      repeat ($urandom_range(1, 3))
        step(1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      kind = $urandom_range(0, 2);
      len  = $urandom_range(4, 110);
      clean(1'b1, 1'b0, 1'b0);
      if (kind == 2) begin
        push_zeros($urandom_range(0, 9));
        push_byte(c_SYNC);
      end
      for (int i = 0; i < 2 * len; i++)
        tx.push_back((kind == 0) ? 1'b0 : bit'($urandom_range(0, 1)));
      while (tx.size() > 1) begin
        n = tx.pop_front();
        p = tx.pop_front();
        dnn = ($urandom_range(0, 49) == 0) ? n : ~n;
        dnp = ($urandom_range(0, 49) == 0) ? p : ~p;
        step(1'b1, n, p, dnn, dnp);
      end
      tx.delete();
    end
    clean(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
